// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
//   btn_state_t      : per-channel debounce state
//   DEBOUNCE_DEFAULT : default qualification length in clk cycles
//   BTN_*            : channel index map for the pico processor wrapper
package btn_pkg;

    typedef enum logic [1:0] {
        REL     = 2'd0,
        REL_CHK = 2'd1,
        PRS     = 2'd2,
        PRS_CHK = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int N_BTN_DEFAULT    = 4;

    localparam int BTN_RESET      = 0;
    localparam int BTN_START_STOP = 1;
    localparam int BTN_INT_REQ    = 2;
    localparam int BTN_PORT_READY = 3;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with stability
// counter, press/release pulses and optional toggle latch.
// Optional feature macro: BTN_TOGGLE_EN (adds btn_toggle output).
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   btn_n       : raw asynchronous button, 0 = pressed
//   btn_level   : debounced level, 1 = pressed
//   btn_press   : one-cycle pulse on accepted press
//   btn_release : one-cycle pulse on accepted release
//   btn_toggle  : inverts after each press (BTN_TOGGLE_EN only)
//
// state   | meaning
// --------+--------------------------------------------------
// REL     | released and stable, waiting for a pressed sample
// REL_CHK | released, qualifying a run of pressed samples
// PRS     | pressed and stable, waiting for a released sample
// PRS_CHK | pressed, qualifying a run of released samples
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
`ifdef BTN_TOGGLE_EN
    ,
    output logic btn_toggle
`endif
);

    // Acceptance happens on the DEBOUNCE_CYCLES-th consecutive sample, i.e.
    // when the count already holds DEBOUNCE_CYCLES-1 and one more agrees.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             s;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    assign s = ~sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= REL;
            count       <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            state       <= state_nxt;
            count       <= count_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            REL: begin
                if (s) begin
                    state_nxt = REL_CHK;
                    count_nxt = CNT_ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            REL_CHK: begin
                if (!s) begin
                    state_nxt = REL;
                    count_nxt = '0;
                end else if (count >= CNT_LAST) begin
                    state_nxt = PRS;
                    count_nxt = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            PRS: begin
                if (!s) begin
                    state_nxt = PRS_CHK;
                    count_nxt = CNT_ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            PRS_CHK: begin
                if (s) begin
                    state_nxt = PRS;
                    count_nxt = '0;
                end else if (count >= CNT_LAST) begin
                    state_nxt   = REL;
                    count_nxt   = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            default: begin
                state_nxt = REL;
                count_nxt = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

`ifdef BTN_TOGGLE_EN
    // Driven from the registered press pulse, so it flips one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_toggle <= 1'b0;
        end else if (btn_press) begin
            btn_toggle <= ~btn_toggle;
        end
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low bouncing push-buttons into clean
// active-high levels plus single-cycle press/release pulses.
// Optional feature macro: BTN_TOGGLE_EN (adds btn_toggle output).
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset (the reset button channel
//                 is only conditioned, it never resets this block)
//   btn_n       : raw buttons, 0 = pressed
//   btn_level   : debounced levels, 1 = pressed
//   btn_press   : one-cycle pulse per channel on accepted press
//   btn_release : one-cycle pulse per channel on accepted release
//   btn_toggle  : per-channel toggle latch (BTN_TOGGLE_EN only)
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
`ifdef BTN_TOGGLE_EN
    ,
    output logic [N_BTN-1:0] btn_toggle
`endif
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_n       (btn_n[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
`ifdef BTN_TOGGLE_EN
            ,
            .btn_toggle  (btn_toggle[i])
`endif
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
`ifdef BTN_TOGGLE_EN
    logic [N-1:0] btn_toggle;
`endif

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
`ifdef BTN_TOGGLE_EN
        ,
        .btn_toggle  (btn_toggle)
`endif
    );

    always #25 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] tog;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a button level flips once the last DEB synchronised
    // samples all disagree with it; samples lag the raw pin by two edges.
    logic [N-1:0]   m_p1 = '0;
    logic [N-1:0]   m_p2 = '0;
    logic [N-1:0]   m_lvl = '0;
    logic [N-1:0]   m_tog = '0;
    logic [N-1:0]   m_prev_press = '0;
    logic [DEB-1:0] m_win [N] = '{default: '0};

    always @(posedge clk) begin : model
        exp_t         e;
        logic [N-1:0] s;
        e = '0;
        if (reset) begin
            m_p1 = '0;
            m_p2 = '0;
            m_lvl = '0;
            m_tog = '0;
            m_prev_press = '0;
            for (int c = 0; c < N; c++) m_win[c] = '0;
        end else begin
            m_tog = m_tog ^ m_prev_press;
            s    = m_p2;
            m_p2 = m_p1;
            m_p1 = ~btn_n;
            for (int c = 0; c < N; c++) begin
                m_win[c] = {m_win[c][DEB-2:0], s[c]};
                if (!m_lvl[c] && (m_win[c] == {DEB{1'b1}})) begin
                    m_lvl[c]   = 1'b1;
                    e.press[c] = 1'b1;
                end else if (m_lvl[c] && (m_win[c] == '0)) begin
                    m_lvl[c] = 1'b0;
                    e.rel[c] = 1'b1;
                end
            end
            m_prev_press = e.press;
        end
        e.level = m_lvl;
        e.tog   = m_tog;
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %b required %b", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("level", btn_level, e.level);
            check("press", btn_press, e.press);
            check("release", btn_release, e.rel);
`ifdef BTN_TOGGLE_EN
            check("toggle", btn_toggle, e.tog);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    // Counts edges from the drive point until btn_level[ch] reaches val.
    task automatic wait_level(input int ch, input logic val, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (btn_level[ch] === val) seen = 1'b1;
        end
        checks++;
        if (!seen || n != LAT) begin
            errors++;
            $display("FAIL %s: level change after %0d edges (seen=%0d) required %0d", name, n, seen, LAT);
        end
    endtask

`ifdef BTN_TOGGLE_EN
    task automatic check_toggle(input int ch, input logic val, input string name);
        @(negedge clk);
        checks++;
        if (btn_toggle[ch] !== val) begin
            errors++;
            $display("FAIL %s: toggle got %b required %b", name, btn_toggle[ch], val);
        end
    endtask
`endif

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int hold [N];
        reset = 1'b1;
        btn_n = '1;
        tick(3);
        reset = 1'b0;
        tick(20);

        // clean press and release
        btn_n[BTN_INT_REQ] = 1'b0;
        wait_level(BTN_INT_REQ, 1'b1, "press_latency");
        tick(14);
        btn_n[BTN_INT_REQ] = 1'b1;
        wait_level(BTN_INT_REQ, 1'b0, "release_latency");
        tick(4);

        // bounce then a too-short low pulse
        for (int i = 0; i < 4; i++) begin
            btn_n[BTN_PORT_READY] = (i % 2 == 1);
            tick(1);
        end
        btn_n[BTN_PORT_READY] = 1'b0;
        tick(3);
        btn_n[BTN_PORT_READY] = 1'b1;
        tick(10);
        check("bounce_level", btn_level, '0);

        // simultaneous press on two channels
        btn_n[BTN_START_STOP] = 1'b0;
        btn_n[BTN_INT_REQ]    = 1'b0;
        wait_level(BTN_START_STOP, 1'b1, "simul_latency");
        check("simul_press", btn_press, 4'b0110);
`ifdef BTN_TOGGLE_EN
        check_toggle(BTN_START_STOP, 1'b1, "toggle_first");
`endif
        tick(6);
        btn_n[BTN_START_STOP] = 1'b1;
        btn_n[BTN_INT_REQ]    = 1'b1;
        wait_level(BTN_START_STOP, 1'b0, "simul_release_latency");
        tick(3);

        // second press on start/stop
        btn_n[BTN_START_STOP] = 1'b0;
        wait_level(BTN_START_STOP, 1'b1, "press2_latency");
`ifdef BTN_TOGGLE_EN
        check_toggle(BTN_START_STOP, 1'b0, "toggle_second");
`endif
        tick(6);
        btn_n[BTN_START_STOP] = 1'b1;
        tick(12);

        // reset during qualification with the button held
        btn_n[BTN_RESET] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        wait_level(BTN_RESET, 1'b1, "reset_requal_latency");
        tick(3);
        btn_n[BTN_RESET] = 1'b1;
        tick(12);

        // randomized holds, mostly around the qualification length
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 2 * DEB + 2);
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    btn_n[c] = ~btn_n[c];
                    hold[c]  = $urandom_range(1, 2 * DEB + 2);
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        reset = 1'b0;
        btn_n = '1;
        tick(20);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the board-level pico processor wrapper.
- Takes the raw, active-low, bouncing push-buttons (reset, start/stop, interrupt request, port ready) and does three things per button:
  - synchronises the input;
  - debounces it;
  - delivers clean active-high levels plus single-cycle press/release pulses.
- The processor's int_req and port_ready inputs and the run/halt control consume these outputs directly.

Parameters:
- N_BTN, 4, number of button channels; index map is in the package.
- DEBOUNCE_CYCLES, 16, number of consecutive cycles a changed synchronised sample must persist before it is accepted; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each channel's stability counter.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_n, input, N_BTN, raw asynchronous buttons; 0 = pressed.
- btn_level, output, N_BTN, debounced state; 1 = pressed.
- btn_press, output, N_BTN, one-cycle pulse when btn_level goes 0->1.
- btn_release, output, N_BTN, one-cycle pulse when btn_level goes 1->0.
- btn_toggle, output, N_BTN, toggle state; present only with BTN_TOGGLE_EN.

Behaviour:
- Synchroniser: 2 flops per channel (sync1, sync2). Reset value is 1 (released). The sample used below is s = ~sync2.
- Per-channel FSM, all registered:
  - REL (level 0): if s=1, count 0->1 and go to REL_CHK; else hold with count=0.
  - REL_CHK: if s=0, go to REL with count=0 (bounce rejected). Else count++. When count reaches DEBOUNCE_CYCLES with s=1, go to PRS; level<=1 and press<=1 on that same edge; count<=0.
  - PRS (level 1): mirror of REL; s=0 goes to PRS_CHK.
  - PRS_CHK: mirror of REL_CHK; acceptance sets level<=0 and release<=1.
- Latency:
  - From the first rising edge that samples a new raw value into sync1 to the edge where btn_level changes: exactly DEBOUNCE_CYCLES+2 edges, provided the raw value stays stable throughout.
  - Any opposite sample during a CHK state restarts qualification from zero.
- Pulses:
  - btn_press and btn_release are high for exactly one cycle.
  - They are never high together on one channel.
  - Press and release on different channels in the same cycle are allowed and independent.
- Minimum accepted pulse: a raw press shorter than DEBOUNCE_CYCLES cycles produces no btn_level change and no pulse.
- Counter saturates:
  - It cannot exceed DEBOUNCE_CYCLES.
  - No wrap-around is possible because CNT_W covers DEBOUNCE_CYCLES.
- Reset values, applied on any edge with reset=1 including mid-qualification:
  - state REL, count 0, sync flops 1;
  - btn_level 0, btn_press 0, btn_release 0, btn_toggle 0.
- The reset-button channel is conditioned like any other channel. It does not reset this block; only the reset port does.
- Button held through reset deassertion: the channel re-qualifies from REL and gets a press pulse DEBOUNCE_CYCLES+2 cycles after reset falls.

Optional Feature:
- Macro: BTN_TOGGLE_EN.
- Defined:
  - btn_toggle exists.
  - Each channel's toggle bit inverts on the cycle after that channel's btn_press. Registered, so latency is 1 cycle after the press pulse.
  - Release has no effect on the toggle bit.
  - Reset clears the toggle bit to 0.
  - Used for the start_stop run/halt latch.
- Undefined: the btn_toggle port and its flops are absent. All other behaviour is identical.

Decomposition:
- Package btn_pkg holds:
  - state enum {REL, REL_CHK, PRS, PRS_CHK};
  - DEBOUNCE_DEFAULT = 16;
  - channel indices BTN_RESET=0, BTN_START_STOP=1, BTN_INT_REQ=2, BTN_PORT_READY=3.
- Sub-module btn_debounce_ch: one channel containing synchroniser, FSM, counter, pulses and optional toggle.
- button_conditioner is a generate loop instantiating N_BTN copies.

Test Plan (bench uses DEBOUNCE_CYCLES=4, clk period 50 ns):
- Reset: hold reset 3 cycles with btn_n=4'b1111 -> all outputs 0; no pulses for 20 cycles.
- Clean press: btn_n[2] 1->0 held 20 cycles -> btn_level[2]=1 exactly 6 edges after the first sampling edge; btn_press[2] high for 1 cycle. On return to 1, btn_release[2] pulses 6 edges later.
- Bounce rejection: btn_n[3] toggles 0,1,0,1 each cycle, then a 3-cycle low pulse -> btn_level[3] stays 0; no press pulse.
- Simultaneous channels: btn_n[1] and btn_n[2] fall on the same edge -> btn_press[1] and btn_press[2] pulse in the same cycle; other bits stay 0.
- Reset mid-qualification: btn_n[0] low, reset asserted at count 2, then released with the button still low -> no pulse before reset; press pulse exactly 6 cycles after reset deasserts.
- BTN_TOGGLE_EN: two separate qualified presses on channel 1 -> btn_toggle[1] goes 0->1 one cycle after the first press pulse and 1->0 one cycle after the second.
